// File: rtl/rename_map_alloc.sv
// rename_map_alloc
// Speculative rename stage: a speculative register alias table (RAT) plus a
// bitmap free list of physical registers. One instruction is renamed per
// cycle: both sources are looked up, a new physical destination is taken
// from the lowest free slot, and the displaced mapping is returned for the
// ROB. Commit frees one physical register per cycle. A flush reloads the
// RAT and free list from the retirement-side copies.
module rename_map_alloc #(
  parameter int A_REG_SIZE = 32,
  parameter int P_REG_SIZE = 128,
  parameter int A_WIDTH    = 5,
  parameter int P_WIDTH    = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          rename_valid,
  output logic                          rename_ready,
  input  logic [A_WIDTH-1:0]            rename_rd,
  input  logic [A_WIDTH-1:0]            rename_rs1,
  input  logic [A_WIDTH-1:0]            rename_rs2,
  output logic [P_WIDTH-1:0]            rename_pd,
  output logic [P_WIDTH-1:0]            rename_pd_old,
  output logic [P_WIDTH-1:0]            rename_ps1,
  output logic [P_WIDTH-1:0]            rename_ps2,
  input  logic [P_WIDTH-1:0]            freed_reg_phys,
  input  logic [P_WIDTH*A_REG_SIZE-1:0] restore_rat,
  input  logic [P_REG_SIZE-1:0]         restore_free_list,
  output logic [P_WIDTH:0]              free_count
);

  // Registered state
  logic [P_WIDTH-1:0]    r_rat [A_REG_SIZE];
  logic [P_REG_SIZE-1:0] r_free_bm;

  // Combinational helpers
  logic [P_WIDTH-1:0]    w_alloc_idx;
  logic                  w_any_free;
  logic [P_WIDTH:0]      w_free_count;
  logic                  w_rd_nonzero;
  logic                  w_fire;
  logic                  w_alloc_en;
  logic                  w_free_en;
  logic [P_WIDTH-1:0]    w_rat_next [A_REG_SIZE];
  logic [P_REG_SIZE-1:0] w_free_next;
  logic                  w_unused_restore;

  // Lowest-index free physical register; scanning downward leaves the
  // lowest set bit as the final assignment.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = P_REG_SIZE - 1; i >= 0; i--) begin
      if (r_free_bm[i]) begin
        w_alloc_idx = P_WIDTH'(i);
      end
    end
  end

  assign w_any_free = |r_free_bm;

  // Population count of the free bitmap.
  always_comb begin
    w_free_count = '0;
    for (int i = 0; i < P_REG_SIZE; i++) begin
      w_free_count = w_free_count + (P_WIDTH + 1)'(r_free_bm[i]);
    end
  end

  assign free_count = w_free_count;

  // Handshake: an rd==0 instruction needs no register, so it never stalls
  // on an empty free list.
  assign w_rd_nonzero = (rename_rd != '0);
  assign rename_ready = !rst && !flush && (!w_rd_nonzero || w_any_free);
  assign w_fire       = rename_valid && rename_ready;
  assign w_alloc_en   = w_fire && w_rd_nonzero;
  // Flush recovery already includes this cycle's commit, so the free is dropped.
  assign w_free_en    = (freed_reg_phys != '0) && !flush;

  // Lookups read the registered RAT, so an rs equal to rd sees the old mapping.
  assign rename_ps1    = r_rat[rename_rs1];
  assign rename_ps2    = r_rat[rename_rs2];
  assign rename_pd_old = r_rat[rename_rd];
  assign rename_pd     = w_rd_nonzero ? w_alloc_idx : '0;

  // Next-state for each RAT entry; entry 0 is hardwired to p0.
  generate
    for (genvar gi = 0; gi < A_REG_SIZE; gi++) begin : g_rat_next
      if (gi == 0) begin : g_zero
        assign w_rat_next[gi] = '0;
      end else begin : g_entry
        assign w_rat_next[gi] =
          flush ? restore_rat[gi*P_WIDTH +: P_WIDTH] :
          (w_alloc_en && (rename_rd == A_WIDTH'(gi))) ? w_alloc_idx :
          r_rat[gi];
      end
    end
  endgenerate

  // Next-state for each free bit. An alloc and a free never target the same
  // bit (the freed bit is 0 before the clock), so both can simply apply.
  // p0 is never allocatable.
  generate
    for (genvar gi = 0; gi < P_REG_SIZE; gi++) begin : g_free_next
      if (gi == 0) begin : g_zero
        assign w_free_next[gi] = 1'b0;
      end else begin : g_bit
        assign w_free_next[gi] =
          flush ? restore_free_list[gi] :
          ((r_free_bm[gi] && !(w_alloc_en && (w_alloc_idx == P_WIDTH'(gi)))) ||
           (w_free_en && (freed_reg_phys == P_WIDTH'(gi))));
      end
    end
  endgenerate

  // Restore slots for p0 / arch r0 carry no information; p0 is hardwired.
  assign w_unused_restore = ^restore_rat[P_WIDTH-1:0] ^ restore_free_list[0];

  // RAT register: identity map on reset, otherwise take the computed next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < A_REG_SIZE; i++) begin
        r_rat[i] <= P_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < A_REG_SIZE; i++) begin
        r_rat[i] <= w_rat_next[i];
      end
    end
  end

  // Free bitmap register: registers above the architectural set start free.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P_REG_SIZE; i++) begin
        r_free_bm[i] <= (i >= A_REG_SIZE);
      end
    end else begin
      r_free_bm <= w_free_next;
    end
  end

endmodule
